// File: rtl/bc_core_pkg.sv
// Shared core definitions: fetch buffer entry layout, instruction size
// and the default reset PC used by the fetch stage.
package bc_core_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/bc_stage_if_if.sv
// Instruction memory bus between the fetch stage (master) and memory (slave).
// req/addr/gnt form the request channel; rvalid/rdata the in-order response.
interface bc_stage_if_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);

    logic                   o_imem_req;
    logic [ADDR_WIDTH-1:0]  o_imem_addr;
    logic                   i_imem_gnt;
    logic                   i_imem_rvalid;
    logic [INSTR_WIDTH-1:0] i_imem_rdata;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata
    );

endinterface

// File: rtl/bc_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and a registered head.
// Ports: push/data in, pop in, flush in; valid/head/count out.
module bc_fetch_fifo
    import bc_core_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  T              i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output T              o_head,
    output logic [CW-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_pop;

    always_comb begin
        do_pop   = i_pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full, a push lands in the slot being popped this cycle.
            if (i_push) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({i_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign o_valid = (count_q != '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/bc_stage_if.sv
// Fetch stage: owns the PC, issues word fetches under a credit limit,
// buffers responses and hands {pc, instr} to decode. Ports: clk/rst,
// imem master bus, redirect in, instr_valid/instr/pc out, id_ready in.
module bc_stage_if
    import bc_core_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    bc_stage_if_if.master          imem,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    input  logic                   i_id_ready
);

    localparam int                    CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q;
    logic [ADDR_WIDTH-1:0] rsp_pc_d;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         outstanding_d;
    logic [CW-1:0]         drop_cnt_q;
    logic [CW-1:0]         drop_cnt_d;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           in_use;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic                  req;
    logic                  issue;
    logic                  rsp;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    entry_t                push_data;
    entry_t                head;
    logic                  unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    always_comb begin
        target_pc       = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        // Buffered plus in-flight words may never exceed the buffer size,
        // so every response always has a free slot.
        in_use          = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req             = !i_rst && !i_redirect
                          && (in_use < (CW+1)'(FIFO_DEPTH));
        issue           = req && imem.i_imem_gnt;
        rsp             = imem.i_imem_rvalid;
        push            = rsp && !i_redirect && (drop_cnt_q == '0);
        pop             = head_valid && i_id_ready && !i_redirect;
        push_data.pc    = rsp_pc_q;
        push_data.instr = imem.i_imem_rdata;

        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (i_redirect) begin
            pc_d          = target_pc;
            rsp_pc_d      = target_pc;
            outstanding_d = outstanding_q - CW'(rsp);
            // Everything still in flight belongs to the old path.
            drop_cnt_d    = outstanding_d;
        end else begin
            if (issue) begin
                pc_d = pc_q + STEP;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + STEP;
            end
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
            if (rsp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    bc_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (pop),
        .o_valid (head_valid),
        .o_head  (head),
        .o_count (fifo_count)
    );

    assign imem.o_imem_req  = req;
    assign imem.o_imem_addr = pc_q;
    assign o_instr_valid    = head_valid && !i_rst;
    assign o_instr          = o_instr_valid ? head.instr : '0;
    assign o_pc             = o_instr_valid ? head.pc : '0;

    assert property (@(posedge i_clk) disable iff (i_rst)
        imem.i_imem_rvalid |-> (outstanding_q != '0));

    assert property (@(posedge i_clk) disable iff (i_rst)
        drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_bc_stage_if.sv
// Testbench for bc_stage_if: directed scenarios plus randomized traffic
// checked against a queue-based model with epoch-tagged requests.
module tb_bc_stage_if;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          id_ready;
    logic          instr_valid;
    logic [IW-1:0] o_instr;
    logic [AW-1:0] o_pc;

    always #5 clk = ~clk;

    bc_stage_if_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    bc_stage_if #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (32'h0),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .imem          (bus),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr_valid (instr_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_id_ready    (id_ready)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            ep;
    } req_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } ent_t;

    req_t          pend[$];
    ent_t          fq[$];
    logic [AW-1:0] fpc;
    int            epoch;
    int            checks;
    int            errors;

    function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic ereq();
        return !rst && !redirect && ((pend.size() + fq.size()) < DEPTH);
    endfunction

    task automatic drive(input logic g, input logic rv, input logic rdy,
                         input logic rd, input logic [AW-1:0] rpc);
        bus.i_imem_gnt    = g;
        bus.i_imem_rvalid = rv && (pend.size() > 0);
        bus.i_imem_rdata  = (pend.size() > 0) ? memf(pend[0].addr) : $urandom;
        id_ready          = rdy;
        redirect          = rd;
        redirect_pc       = rpc;
        #3;
    endtask

    task automatic tick();
        logic          iss;
        logic          rv;
        logic          rdy;
        logic          rd;
        logic          r;
        logic          vld;
        logic [AW-1:0] rpc;
        ent_t          e;
        req_t          q;
        r   = rst;
        rd  = redirect;
        rpc = redirect_pc;
        rv  = bus.i_imem_rvalid;
        rdy = id_ready;
        iss = ereq() && bus.i_imem_gnt;
        vld = fq.size() > 0;
        @(posedge clk);
        if (r) begin
            pend.delete();
            fq.delete();
            fpc = '0;
            epoch++;
        end else begin
            if (vld && rdy && !rd) e = fq.pop_front();
            if (rv) begin
                q = pend.pop_front();
                if (!rd && q.ep == epoch) begin
                    e.pc  = q.addr;
                    e.ins = memf(q.addr);
                    fq.push_back(e);
                end
            end
            if (iss) begin
                q.addr = fpc;
                q.ep   = epoch;
                pend.push_back(q);
                fpc += 4;
            end
            if (rd) begin
                fq.delete();
                epoch++;
                fpc = {rpc[AW-1:2], 2'b00};
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, '0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 1, 0, '0);
        checks++;
        if (bus.o_imem_req !== 1'b0 || instr_valid !== 1'b0
            || o_instr !== '0 || o_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h required 0",
                     bus.o_imem_req, instr_valid, o_instr, o_pc);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 1, 0, '0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0
            || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: req=%b addr=%h valid=%b required 1/0/0",
                     bus.o_imem_req, bus.o_imem_addr, instr_valid);
        end
        tick();
    endtask

    task automatic test_stream();
        int first_iss = -1;
        int first_vld = -1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 1, 0, '0);
            if (first_iss < 0 && bus.o_imem_req && bus.i_imem_gnt) first_iss = i;
            if (first_vld < 0 && instr_valid) first_vld = i;
            if (ereq()) begin
                checks++;
                if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== fpc) begin
                    errors++;
                    $display("FAIL stream_addr: req=%b addr=%h required 1/%h",
                             bus.o_imem_req, bus.o_imem_addr, fpc);
                end
            end
            if (first_vld >= 0 && i == first_vld) begin
                checks++;
                if (o_pc !== 32'h0 || o_instr !== memf(32'h0)) begin
                    errors++;
                    $display("FAIL stream_first: pc=%h instr=%h required 0/%h",
                             o_pc, o_instr, memf(32'h0));
                end
            end
            if (first_vld >= 0 && i == first_vld + 1) begin
                checks++;
                if (instr_valid !== 1'b1 || o_pc !== 32'h4) begin
                    errors++;
                    $display("FAIL stream_second: valid=%b pc=%h required 1/4",
                             instr_valid, o_pc);
                end
            end
            tick();
        end
        checks++;
        if (first_iss < 0 || first_vld - first_iss != 2) begin
            errors++;
            $display("FAIL stream_latency: issue@%0d valid@%0d required gap 2",
                     first_iss, first_vld);
        end
    endtask

    task automatic test_backpressure();
        int            n = 0;
        int            rel_addr = -1;
        logic [AW-1:0] exp_pc = '0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0, '0);
            if (bus.o_imem_req && bus.i_imem_gnt) n++;
            tick();
        end
        drive(1, 1, 0, 0, '0);
        checks++;
        if (n != DEPTH || bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_issues: issued=%0d req=%b required %0d/0",
                     n, bus.o_imem_req, DEPTH);
        end
        checks++;
        if (instr_valid !== 1'b1 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full_head: valid=%b pc=%h required 1/0",
                     instr_valid, o_pc);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0, '0);
            if (rel_addr < 0 && bus.o_imem_req) rel_addr = int'(bus.o_imem_addr);
            if (instr_valid) begin
                checks++;
                if (o_pc !== exp_pc || o_instr !== memf(exp_pc)) begin
                    errors++;
                    $display("FAIL bp_drain: pc=%h instr=%h required %h/%h",
                             o_pc, o_instr, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
            end
            tick();
        end
        checks++;
        if (rel_addr != 8 || exp_pc < 32'h8) begin
            errors++;
            $display("FAIL bp_resume: addr=%h drained_to=%h required 8/>=8",
                     rel_addr, exp_pc);
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, '0);
            checks++;
            if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0
                || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: req=%b addr=%h valid=%b required 1/0/0",
                         bus.o_imem_req, bus.o_imem_addr, instr_valid);
            end
            tick();
        end
        drive(1, 1, 1, 0, '0);
        tick();
        drive(0, 1, 1, 0, '0);
        checks++;
        if (bus.o_imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL stall_advance: addr=%h required 4", bus.o_imem_addr);
        end
        tick();
    endtask

    task automatic test_redirect_drop();
        logic seen = 1'b0;
        do_reset();
        drive(1, 0, 1, 0, '0);
        tick();
        drive(1, 0, 1, 0, '0);
        tick();
        drive(1, 0, 1, 1, 32'h100);
        checks++;
        if (bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rd_req_gate: req=%b required 0", bus.o_imem_req);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, '0);
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_drop: valid=%b pc=%h required 0", instr_valid, o_pc);
            end
            tick();
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(1, 1, 1, 0, '0);
            if (instr_valid) begin
                seen = 1'b1;
                checks++;
                if (o_pc !== 32'h100 || o_instr !== memf(32'h100)) begin
                    errors++;
                    $display("FAIL rd_target: pc=%h instr=%h required 100/%h",
                             o_pc, o_instr, memf(32'h100));
                end
            end
            tick();
        end
        if (!seen) begin
            errors++;
            $display("FAIL rd_timeout: no instruction after redirect");
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        drive(1, 0, 1, 0, '0);
        tick();
        drive(1, 0, 1, 0, '0);
        tick();
        drive(0, 1, 0, 0, '0);
        tick();
        drive(1, 1, 1, 1, 32'h203);
        checks++;
        if (instr_valid !== 1'b1 || bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL sc_pre: valid=%b req=%b required 1/0",
                     instr_valid, bus.o_imem_req);
        end
        tick();
        drive(0, 0, 1, 0, '0);
        checks++;
        if (instr_valid !== 1'b0 || bus.o_imem_req !== 1'b1
            || bus.o_imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL sc_post: valid=%b req=%b addr=%h required 0/1/200",
                     instr_valid, bus.o_imem_req, bus.o_imem_addr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic seen = 1'b0;
        do_reset();
        drive(1, 0, 1, 0, '0);
        tick();
        drive(0, 0, 1, 1, 32'h40);
        tick();
        drive(0, 0, 1, 1, 32'h80);
        tick();
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(1, 1, 1, 0, '0);
            if (i == 0) begin
                checks++;
                if (bus.o_imem_addr !== 32'h80) begin
                    errors++;
                    $display("FAIL b2b_addr: addr=%h required 80", bus.o_imem_addr);
                end
            end
            if (instr_valid) begin
                seen = 1'b1;
                checks++;
                if (o_pc !== 32'h80 || o_instr !== memf(32'h80)) begin
                    errors++;
                    $display("FAIL b2b_first: pc=%h instr=%h required 80/%h",
                             o_pc, o_instr, memf(32'h80));
                end
            end
            tick();
        end
        if (!seen) begin
            errors++;
            $display("FAIL b2b_timeout: no instruction after redirects");
        end
    endtask

    task automatic test_random();
        logic g;
        logic rv;
        logic rdy;
        logic rd;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            g   = ($urandom_range(0, 3) != 0);
            rv  = !rst && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            drive(g, rv, rdy, rd, $urandom);
            checks++;
            if (bus.o_imem_req !== ereq()) begin
                errors++;
                $display("FAIL rnd_req @%0d: req=%b required %b",
                         i, bus.o_imem_req, ereq());
            end
            if (ereq()) begin
                checks++;
                if (bus.o_imem_addr !== fpc) begin
                    errors++;
                    $display("FAIL rnd_addr @%0d: addr=%h required %h",
                             i, bus.o_imem_addr, fpc);
                end
            end
            checks++;
            if (instr_valid !== (!rst && fq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_valid @%0d: valid=%b required %b",
                         i, instr_valid, !rst && fq.size() > 0);
            end
            if (!rst && fq.size() > 0) begin
                checks++;
                if (o_pc !== fq[0].pc || o_instr !== fq[0].ins) begin
                    errors++;
                    $display("FAIL rnd_head @%0d: pc=%h instr=%h required %h/%h",
                             i, o_pc, o_instr, fq[0].pc, fq[0].ins);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        epoch             = 0;
        fpc               = '0;
        rst               = 1'b1;
        redirect          = 1'b0;
        redirect_pc       = '0;
        id_ready          = 1'b0;
        bus.i_imem_gnt    = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
